// File: rtl/id_hazard_ctrl_if.sv
// Decode-side handshake between the ID stage and the issue-interlock controller.
// The decoder drives the master side; id_hazard_ctrl sits on the slave side.
interface id_hazard_ctrl_if;
    logic       id_valid_inst;
    logic [4:0] id_ra_idx;
    logic [4:0] id_rb_idx;
    logic       id_uses_ra;
    logic       id_uses_rb;
    logic       id_reg_wr;
    logic [4:0] id_dest_idx;
    logic       ex_take_branch;
    logic       stall_if;
    logic       bubble_ex;
    logic       issue;
    logic       flush_id;

    modport master (
        output id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb,
               id_reg_wr, id_dest_idx, ex_take_branch,
        input  stall_if, bubble_ex, issue, flush_id
    );

    modport slave (
        input  id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb,
               id_reg_wr, id_dest_idx, ex_take_branch,
        output stall_if, bubble_ex, issue, flush_id
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Issue interlock for the 5-stage pipeline: shift-register scoreboard of in-flight
// destinations, RAW stall / taken-branch flush sequencing, saturating perf counters.
module id_hazard_ctrl #(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    id_hazard_ctrl_if.slave   id,
    output logic [31:0]       busy_mask,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            sb_v   [DEPTH];
    logic [4:0]      sb_idx [DEPTH];
    logic            hazard;
    logic            flush_now;

    // busy_mask doubles as the match() lookup for both source operands
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sb_v[i]) busy_mask[sb_idx[i]] = 1'b1;
        end
    end

    always_comb begin
        hazard = id.id_valid_inst &
                 ((id.id_uses_ra & (id.id_ra_idx != 5'd0) & busy_mask[id.id_ra_idx]) |
                  (id.id_uses_rb & (id.id_rb_idx != 5'd0) & busy_mask[id.id_rb_idx]));
        flush_now = id.ex_take_branch | (state_q == FLUSH);
    end

    always_comb begin
        id.flush_id  = 1'b0;
        id.stall_if  = 1'b0;
        id.bubble_ex = 1'b0;
        id.issue     = 1'b0;
        if (flush_now) begin
            id.flush_id  = 1'b1;
            id.bubble_ex = 1'b1;
        end else if (hazard) begin
            id.stall_if  = 1'b1;
            id.bubble_ex = 1'b1;
        end else begin
            id.issue     = id.id_valid_inst;
            id.bubble_ex = ~id.id_valid_inst;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN, STALL: begin
                if (id.ex_take_branch) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_LOAD;
                end else if (hazard) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (id.ex_take_branch) begin
                    fcnt_d = FC_LOAD;
                end else if (fcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Older entries (including a resolving branch) keep shifting through a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sb_v[i]   <= 1'b0;
                sb_idx[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sb_v[i]   <= sb_v[i-1];
                sb_idx[i] <= sb_idx[i-1];
            end
            if (id.issue) begin
                sb_v[0]   <= id.id_reg_wr & (id.id_dest_idx != 5'd0);
                sb_idx[0] <= id.id_dest_idx;
            end else begin
                sb_v[0]   <= 1'b0;
                sb_idx[0] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && !flush_now && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (id.ex_take_branch && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: RAW stall latency, x0 handling, operand-use
// gating, branch flush sequencing and counter saturation (4-bit counters).
module tb_id_hazard_ctrl;
    logic        clk;
    logic        rst;
    logic [31:0] busy_mask;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;
    int          checks;
    int          errors;

    id_hazard_ctrl_if ifc ();

    id_hazard_ctrl #(.DEPTH(3), .FLUSH_LEN(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .id        (ifc),
        .busy_mask (busy_mask),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] ra, input logic ura,
                         input logic [4:0] rb, input logic urb,
                         input logic wr, input logic [4:0] rd);
        ifc.id_valid_inst = v;
        ifc.id_ra_idx     = ra;
        ifc.id_uses_ra    = ura;
        ifc.id_rb_idx     = rb;
        ifc.id_uses_rb    = urb;
        ifc.id_reg_wr     = wr;
        ifc.id_dest_idx   = rd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ifc.ex_take_branch = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        step();
        step();
        rst = 1'b1;
    endtask

    // Counts stall cycles until the held instruction issues; -1 on timeout.
    task automatic wait_issue(output int stalls);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.issue) break;
            if (ifc.stall_if) stalls++;
            step();
        end
        if (!ifc.issue) stalls = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.ex_take_branch = 1'b0;
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1);
        checks++; if (ifc.stall_if !== 1'b0) begin errors++; $display("FAIL rst_stall_if got %b exp 0", ifc.stall_if); end
        checks++; if (ifc.flush_id !== 1'b0) begin errors++; $display("FAIL rst_flush_id got %b exp 0", ifc.flush_id); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL rst_busy_mask got %h exp 0", busy_mask); end
        checks++; if (ifc.issue !== 1'b1 || ifc.bubble_ex !== 1'b0) begin errors++; $display("FAIL rst_issue got %b/%b exp 1/0", ifc.issue, ifc.bubble_ex); end
        checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        step();
        rst = 1'b1;
        step();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        checks++; if (ifc.stall_if !== 1'b1 || busy_mask !== 32'h2) begin errors++; $display("FAIL pre_rst_stall got %b/%h exp 1/2", ifc.stall_if, busy_mask); end
        rst = 1'b0;
        #1;
        checks++; if (busy_mask !== 32'h0 || ifc.stall_if !== 1'b0 || ifc.issue !== 1'b1) begin errors++; $display("FAIL midstall_rst got %h/%b/%b exp 0/0/1", busy_mask, ifc.stall_if, ifc.issue); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (ifc.issue !== 1'b1 || ifc.stall_if !== 1'b0) begin errors++; $display("FAIL post_rst_issue got %b/%b exp 1/0", ifc.issue, ifc.stall_if); end
        step();
    endtask

    task automatic test_back_to_back();
        int s;
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1);
        step();
        drive(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd4);
        checks++; if (ifc.bubble_ex !== 1'b1 || ifc.issue !== 1'b0) begin errors++; $display("FAIL b2b_bubble got %b/%b exp 1/0", ifc.bubble_ex, ifc.issue); end
        wait_issue(s);
        checks++; if (s !== 3) begin errors++; $display("FAIL b2b_stalls got %0d exp 3", s); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL b2b_stall_cnt got %0d exp 3", stall_cnt); end
        step();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        checks++; if (busy_mask !== 32'h10) begin errors++; $display("FAIL b2b_busy got %h exp 10", busy_mask); end
    endtask

    task automatic test_distance_and_x0();
        int s;
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd6);
        step();
        drive(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 5'd7);
        checks++; if (ifc.issue !== 1'b1) begin errors++; $display("FAIL dist_indep_issue got %b exp 1", ifc.issue); end
        step();
        drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        wait_issue(s);
        checks++; if (s !== 2) begin errors++; $display("FAIL dist2_stalls got %0d exp 2", s); end
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0);
        step();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd5);
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL x0_busy got %h exp 0", busy_mask); end
        wait_issue(s);
        checks++; if (s !== 0) begin errors++; $display("FAIL x0_stalls got %0d exp 0", s); end
    endtask

    task automatic test_uses_rb();
        int s;
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd10);
        step();
        drive(1'b1, 5'd11, 1'b1, 5'd10, 1'b0, 1'b0, 5'd0);
        checks++; if (ifc.issue !== 1'b1 || ifc.stall_if !== 1'b0) begin errors++; $display("FAIL itype_no_stall got %b/%b exp 1/0", ifc.issue, ifc.stall_if); end
        step();
        drive(1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 1'b0, 5'd0);
        wait_issue(s);
        checks++; if (s !== 2) begin errors++; $display("FAIL rtype_rb_stalls got %0d exp 2", s); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1);
        step();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        checks++; if (ifc.stall_if !== 1'b1) begin errors++; $display("FAIL br_pre_stall got %b exp 1", ifc.stall_if); end
        step();
        ifc.ex_take_branch = 1'b1;
        #1;
        checks++; if (ifc.flush_id !== 1'b1 || ifc.stall_if !== 1'b0 || ifc.issue !== 1'b0 || ifc.bubble_ex !== 1'b1) begin errors++; $display("FAIL br_same_cycle got %b%b%b%b exp 1001", ifc.flush_id, ifc.stall_if, ifc.issue, ifc.bubble_ex); end
        step();
        ifc.ex_take_branch = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        checks++; if (ifc.flush_id !== 1'b1) begin errors++; $display("FAIL br_flush1 got %b exp 1", ifc.flush_id); end
        step();
        checks++; if (ifc.flush_id !== 1'b1) begin errors++; $display("FAIL br_flush2 got %b exp 1", ifc.flush_id); end
        step();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        checks++; if (ifc.flush_id !== 1'b0 || ifc.issue !== 1'b1) begin errors++; $display("FAIL br_back_to_run got %b/%b exp 0/1", ifc.flush_id, ifc.issue); end
        checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin errors++; $display("FAIL br_cnts got %0d/%0d exp 1/1", flush_cnt, stall_cnt); end
    endtask

    task automatic test_flush_reload();
        do_reset();
        ifc.ex_take_branch = 1'b1;
        #1;
        step();
        ifc.ex_take_branch = 1'b0;
        #1;
        step();
        ifc.ex_take_branch = 1'b1;
        #1;
        step();
        ifc.ex_take_branch = 1'b0;
        #1;
        checks++; if (ifc.flush_id !== 1'b1) begin errors++; $display("FAIL reload_flush1 got %b exp 1", ifc.flush_id); end
        step();
        checks++; if (ifc.flush_id !== 1'b1) begin errors++; $display("FAIL reload_flush2 got %b exp 1", ifc.flush_id); end
        step();
        checks++; if (ifc.flush_id !== 1'b0 || flush_cnt !== 4'd2) begin errors++; $display("FAIL reload_end got %b/%0d exp 0/2", ifc.flush_id, flush_cnt); end
    endtask

    task automatic test_saturation();
        int s;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1);
            step();
            drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
            wait_issue(s);
            step();
            if (r == 4) begin
                checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got %0d exp 15", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_back_to_back();
        test_distance_and_x0();
        test_uses_rb();
        test_branch_flush();
        test_flush_reload();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Issue-interlock controller for the in-order 5-stage RISC-V pipeline.
- Sits beside the decode stage. Tracks destination registers of instructions in flight downstream of decode (ID/EX, EX/MEM, MEM/WB) in a shift-register scoreboard.
- Stalls fetch/decode and injects bubbles into ID/EX on read-after-write hazards. Runs a flush sequence when EX resolves a taken branch or jump.
- Replaces the purely combinational index compare in decode and keeps saturating performance counters.

Parameters:
- DEPTH, 3: scoreboard entries (pipeline slots between decode and register-file write, WB included; no regfile bypass).
- FLUSH_LEN, 2: cycles of squash after a taken branch (instructions in IF and ID).
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- id_valid_inst  in  1  decode holds a valid, legal instruction
- id_ra_idx  in  5  rs1 index
- id_rb_idx  in  5  rs2 index
- id_uses_ra  in  1  instruction reads rs1
- id_uses_rb  in  1  instruction reads rs2
- id_reg_wr  in  1  instruction writes rd
- id_dest_idx  in  5  rd index
- ex_take_branch  in  1  instruction now in EX redirects PC (taken branch, JAL, JALR)
- stall_if  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load noop (valid=0) into ID/EX
- issue  out  1  decode instruction advances into ID/EX this cycle
- flush_id  out  1  invalidate IF/ID contents
- busy_mask  out  32  bit r set when any valid entry targets xr (debug)
- stall_cnt  out  CNT_W  cycles stalled on hazards
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Scoreboard: DEPTH entries {v, idx[4:0]}; entry 0 is the ID/EX slot. Every cycle, entry[i] <= entry[i-1] for i >= 1. Entry[0] <= issue ? {id_reg_wr & (id_dest_idx != 0), id_dest_idx} : {0, 0}.
- Writes to x0 never occupy an entry. Sources reading x0 never match.
- match(r) = OR over i of (entry[i].v & entry[i].idx == r).
- hazard = id_valid_inst & ((id_uses_ra & ra != 0 & match(ra)) | (id_uses_rb & rb != 0 & match(rb))).
- FSM states:
  - RUN:
    - If ex_take_branch, go to FLUSH with fcnt = FLUSH_LEN-1.
    - Else if hazard, go to STALL.
    - Else stay in RUN.
  - STALL:
    - If ex_take_branch, go to FLUSH (priority over the stall).
    - Else if !hazard, go to RUN.
    - Else stay in STALL.
  - FLUSH:
    - If fcnt == 0, go to RUN; else decrement fcnt.
    - A new ex_take_branch while in FLUSH reloads fcnt = FLUSH_LEN-1.
- Outputs are combinational from state and inputs; evaluation is the same cycle:
  - flush condition (ex_take_branch, or state == FLUSH): flush_id=1, bubble_ex=1, issue=0, stall_if=0.
  - else hazard: stall_if=1, bubble_ex=1, issue=0.
  - else: issue = id_valid_inst, bubble_ex = !id_valid_inst, stall_if=0.
- Latency: a consumer issued directly after its producer stalls exactly DEPTH cycles. It issues on the cycle the producer leaves the last entry.
- Counters:
  - stall_cnt increments on each cycle where hazard is set and there is no flush.
  - flush_cnt increments on each ex_take_branch cycle.
  - Both counters saturate at all-ones and do not wrap.
- Reset (rst low, asynchronous): all entries invalid, state RUN, fcnt=0, counters=0. Outputs at reset: stall_if=0, flush_id=0, busy_mask=0, issue/bubble_ex follow id_valid_inst. Reset mid-stall or mid-flush discards all pending state.
- The branch instruction's own entry, already in the scoreboard, is retained through a flush. Only younger instructions are squashed.

Test Plan:
- Reset mid-STALL: scoreboard holds x1, rst low -> busy_mask=0, stall_if=0 immediately. After release, a consumer of x1 issues with no stall.
- Back-to-back RAW: add x1,x2,x3 then add x4,x1,x5 -> stall_if=1 for exactly 3 cycles, stall_cnt=3, consumer issue=1 on the 4th cycle.
- Distance 2: producer of x6, one independent instruction, then consumer of x6 -> 2 stall cycles. x0 writer followed by an x0 reader -> 0 stalls.
- rs2-only hazard with id_uses_rb=0 (I-type) -> no stall. With id_uses_rb=1 -> stall.
- ex_take_branch during STALL -> same cycle flush_id=1, stall_if=0. 2 flush cycles, flush_cnt=1, then RUN.
- Saturation: preload stall_cnt = all-ones (CNT_W=4 build, 15) and stall once more -> stall_cnt stays 15.
